// File: rtl/nn_pkg.sv
// Shared encodings for the neuron datapath: activation modes, FSM states and
// the leaky-ReLU shift.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Negative inputs to leaky ReLU are scaled by 1/8.
    localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up from 2*FRAC_BITS to FRAC_BITS fractional bits,
// followed by saturation to a signed WIDTH-bit result with a clamp flag.
module fxp_round_sat #(
    parameter int ACC_W     = 21,
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 6
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] res,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(1 << (WIDTH - 1)));

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    // ACC_W leaves headroom above the largest dot product, so adding HALF cannot wrap.
    assign sum     = acc + HALF;
    assign shifted = sum >>> FRAC_BITS;

    always_comb begin
        res = shifted[WIDTH-1:0];
        sat = 1'b0;
        if (shifted > MAX_V) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_dot_unit.sv
// Sequential fixed-point neuron: biased dot product over a valid/ready operand
// stream, rounded, saturated and activated onto a valid/ready result port.
module neuron_dot_unit
    import nn_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  INT_BITS  = 2,
    parameter int  MAX_LEN   = 16,
    localparam int FRAC_BITS = WIDTH - INT_BITS,
    localparam int LEN_W     = $clog2(MAX_LEN + 1),
    localparam int ACC_W     = 2 * WIDTH + $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] bias,
    input  logic [1:0]       act_mode,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             sat
);

    state_t                  state;
    state_t                  state_nxt;
    act_mode_t               mode_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        count_q;
    logic [LEN_W-1:0]        len_eff;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] rs_val;
    logic signed [WIDTH-1:0] act_val;
    logic [WIDTH-1:0]        out_q;
    logic                    rs_sat;
    logic                    sat_q;
    logic                    beat;
    logic                    last_beat;

    assign len_eff   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign beat      = (state == S_ACCUM) && in_valid;
    assign last_beat = beat && (count_q == len_q - LEN_W'(1));

    // Bias is aligned to the product scale (2*FRAC_BITS fractional bits).
    assign bias_ext = {{(ACC_W-WIDTH-FRAC_BITS){bias[WIDTH-1]}}, bias, {FRAC_BITS{1'b0}}};
    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    fxp_round_sat #(
        .ACC_W     (ACC_W),
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc (acc_q),
        .res (rs_val),
        .sat (rs_sat)
    );

    always_comb begin
        act_val = rs_val;
        case (mode_q)
            ACT_RELU:  if (rs_val < 0) act_val = '0;
            ACT_LEAKY: if (rs_val < 0) act_val = rs_val >>> LEAKY_SHIFT;
            default:   act_val = rs_val;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len_eff == '0) ? S_FINAL : S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= ACT_NONE;
            len_q   <= '0;
            count_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= act_mode_t'(act_mode);
                        len_q   <= len_eff;
                        count_q <= '0;
                        acc_q   <= bias_ext;
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        acc_q   <= acc_q + prod_ext;
                        count_q <= count_q + LEN_W'(1);
                    end
                end
                S_FINAL: begin
                    out_q <= act_val;
                    sat_q <= rs_sat;
                end
                default: begin
                end
            endcase
        end
    end

    assign out = out_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_neuron_dot_unit.sv
// Directed self-checking bench for neuron_dot_unit (WIDTH=8, Q2.6, 1.0 = 64).
module tb_neuron_dot_unit;
    import nn_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic [7:0] bias = '0;
    logic [1:0] act_mode = '0;
    logic       busy;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic       sat;

    int errors = 0;
    int checks = 0;

    logic [7:0] op_a [16];
    logic [7:0] op_b [16];
    logic [7:0] res_out;
    logic       res_sat;
    int         res_lat;
    logic       ir_seen;

    neuron_dot_unit #(
        .WIDTH    (8),
        .INT_BITS (2),
        .MAX_LEN  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .act_mode  (act_mode),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] va, input logic [7:0] vb);
        for (int i = 0; i < n; i++) begin
            op_a[i] = va;
            op_b[i] = vb;
        end
    endtask

    // Issues a command, streams n beats (gap idle cycles between beats) and
    // waits, bounded, for out_valid. res_lat counts the acceptance edge as 1.
    task automatic run_op(input int len_v, input int n, input logic [7:0] bias_v,
                          input logic [1:0] mode_v, input int gap);
        int g;
        start    = 1'b1;
        len      = len_v[4:0];
        bias     = bias_v;
        act_mode = mode_v;
        tick;
        start   = 1'b0;
        ir_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = op_a[i];
            b = op_b[i];
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 20) begin
                tick;
                g++;
            end
            tick;
            in_valid = 1'b0;
            if (i < n - 1) begin
                for (int k = 0; k < gap; k++) tick;
            end
        end
        res_lat = 1;
        while (!out_valid && res_lat < 12) begin
            if (in_ready) ir_seen = 1'b1;
            tick;
            res_lat++;
        end
        res_out = out;
        res_sat = sat;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        checks++; if (out !== 8'd0)      begin errors++; $display("FAIL reset_out: got %0d want 0", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sat !== 1'b0)      begin errors++; $display("FAIL reset_sat: got %b want 0", sat); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_basic;
        fill(2, 8'd32, 8'd64);
        run_op(2, 2, 8'd16, ACT_RELU, 0);
        checks++; if (res_out !== 8'd80) begin errors++; $display("FAIL basic_out: got %0d want 80", $signed(res_out)); end
        checks++; if (res_sat !== 1'b0)  begin errors++; $display("FAIL basic_sat: got %b want 0", res_sat); end
        checks++; if (res_lat != 2)      begin errors++; $display("FAIL basic_latency: got %0d want 2", res_lat); end
        handshake;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
        checks++; if (out !== 8'd80)      begin errors++; $display("FAIL basic_out_kept: got %0d want 80", $signed(out)); end
    endtask

    task automatic test_saturation;
        fill(3, 8'd64, 8'd64);
        run_op(3, 3, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'd127) begin errors++; $display("FAIL sat_pos_out: got %0d want 127", $signed(res_out)); end
        checks++; if (res_sat !== 1'b1)   begin errors++; $display("FAIL sat_pos_flag: got %b want 1", res_sat); end
        handshake;
        fill(3, 8'd64, 8'(-64));
        run_op(3, 3, 8'd0, ACT_RELU, 0);
        checks++; if (res_out !== 8'd0) begin errors++; $display("FAIL sat_neg_relu_out: got %0d want 0", $signed(res_out)); end
        checks++; if (res_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_relu_flag: got %b want 1", res_sat); end
        handshake;
        run_op(3, 3, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'h80) begin errors++; $display("FAIL sat_neg_out: got %0d want -128", $signed(res_out)); end
        handshake;
    endtask

    task automatic test_leaky_rounding;
        fill(1, 8'd64, 8'(-32));
        run_op(1, 1, 8'd0, ACT_LEAKY, 0);
        checks++; if (res_out !== 8'(-4)) begin errors++; $display("FAIL leaky_out: got %0d want -4", $signed(res_out)); end
        checks++; if (res_sat !== 1'b0)   begin errors++; $display("FAIL leaky_sat: got %b want 0", res_sat); end
        handshake;
        fill(1, 8'd1, 8'd32);
        run_op(1, 1, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'd1) begin errors++; $display("FAIL round_half_up: got %0d want 1", $signed(res_out)); end
        handshake;
        fill(1, 8'd1, 8'd31);
        run_op(1, 1, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'd0) begin errors++; $display("FAIL round_below_half: got %0d want 0", $signed(res_out)); end
        handshake;
        fill(1, 8'd64, 8'(-32));
        run_op(1, 1, 8'd0, ACT_RSVD, 0);
        checks++; if (res_out !== 8'(-32)) begin errors++; $display("FAIL reserved_mode: got %0d want -32", $signed(res_out)); end
        handshake;
    endtask

    task automatic test_zero_len;
        run_op(0, 0, 8'(-16), ACT_NONE, 0);
        checks++; if (res_out !== 8'(-16)) begin errors++; $display("FAIL zero_len_out: got %0d want -16", $signed(res_out)); end
        checks++; if (res_lat != 2)        begin errors++; $display("FAIL zero_len_latency: got %0d want 2", res_lat); end
        checks++; if (ir_seen !== 1'b0)    begin errors++; $display("FAIL zero_len_in_ready: got %b want 0", ir_seen); end
        handshake;
    endtask

    task automatic test_len_clamp;
        fill(16, 8'd8, 8'd8);
        run_op(31, 16, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'd16) begin errors++; $display("FAIL len_clamp_out: got %0d want 16", $signed(res_out)); end
        checks++; if (res_lat != 2)      begin errors++; $display("FAIL len_clamp_latency: got %0d want 2", res_lat); end
        handshake;
    endtask

    task automatic test_stalls;
        fill(2, 8'd32, 8'd64);
        run_op(2, 2, 8'd16, ACT_RELU, 3);
        checks++; if (res_out !== 8'd80) begin errors++; $display("FAIL stall_out: got %0d want 80", $signed(res_out)); end
        checks++; if (res_lat != 2)      begin errors++; $display("FAIL stall_latency: got %0d want 2", res_lat); end
        handshake;
    endtask

    task automatic test_backpressure;
        fill(2, 8'd32, 8'd64);
        run_op(2, 2, 8'd16, ACT_RELU, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start    = 1'b1;
                len      = 5'd1;
                bias     = 8'd0;
                act_mode = ACT_NONE;
                in_valid = 1'b1;
                a        = 8'd64;
                b        = 8'd64;
            end
            tick;
            start    = 1'b0;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out !== 8'd80) begin
                errors++;
                $display("FAIL hold_stable_%0d: got valid=%b out=%0d want valid=1 out=80", c, out_valid, $signed(out));
            end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
        handshake;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        fill(1, 8'd1, 8'd32);
        run_op(1, 1, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'd1) begin errors++; $display("FAIL b2b_first: got %0d want 1", $signed(res_out)); end
        handshake;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
        fill(1, 8'd64, 8'(-32));
        run_op(1, 1, 8'd0, ACT_LEAKY, 0);
        checks++; if (res_out !== 8'(-4)) begin errors++; $display("FAIL b2b_second: got %0d want -4", $signed(res_out)); end
        checks++; if (res_lat != 2)       begin errors++; $display("FAIL b2b_latency: got %0d want 2", res_lat); end
        handshake;
    endtask

    task automatic test_reset_mid;
        fill(1, 8'd32, 8'd64);
        run_op(1, 1, 8'd16, ACT_NONE, 0);
        handshake;
        start    = 1'b1;
        len      = 5'd3;
        bias     = 8'd16;
        act_mode = ACT_NONE;
        tick;
        start    = 1'b0;
        a        = 8'd64;
        b        = 8'd64;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        reset    = 1'b1;
        tick;
        reset    = 1'b0;
        checks++;
        if (out !== 8'd0 || out_valid !== 1'b0 || sat !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got out=%0d valid=%b sat=%b busy=%b in_ready=%b want all 0",
                     $signed(out), out_valid, sat, busy, in_ready);
        end
        fill(1, 8'd64, 8'd64);
        run_op(1, 1, 8'd0, ACT_NONE, 0);
        checks++; if (res_out !== 8'd64) begin errors++; $display("FAIL reset_fresh_out: got %0d want 64", $signed(res_out)); end
        checks++; if (res_sat !== 1'b0)  begin errors++; $display("FAIL reset_fresh_sat: got %b want 0", res_sat); end
        handshake;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_leaky_rounding;
        test_zero_len;
        test_len_clamp;
        test_stalls;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
